// File: rtl/clock_div_pkg.sv
// Shared types and default sizing for the clock-enable divider bank.
package clock_div_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } div_mode_t;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_WIDTH    = 8;

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: rollover counter, shadow divisor, strobe and derived clock.
module clock_div_channel
    import clock_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_sync,
    input  logic             i_en,
    input  div_mode_t        i_mode,
    input  logic [WIDTH-1:0] i_div,
    output logic             o_roll_over,
    output logic             o_clk,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             roll_q, roll_d;
    logic             clk_q, clk_d;

    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        roll_d   = 1'b0;
        clk_d    = clk_q;

        // The counter only returns to zero through the compare, so a full-range
        // divisor never relies on arithmetic overflow.
        if (i_en) begin
            if (cnt_q == shadow_q) begin
                cnt_d    = '0;
                roll_d   = 1'b1;
                shadow_d = i_div;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end

        if (i_mode == MODE_PULSE) begin
            clk_d = roll_d;
        end else if (roll_d) begin
            clk_d = ~clk_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_sync) begin
            cnt_q    <= '0;
            shadow_q <= i_div;
            roll_q   <= 1'b0;
            clk_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            roll_q   <= roll_d;
            clk_q    <= clk_d;
        end
    end

    assign o_roll_over = roll_q;
    assign o_clk       = clk_q;
    assign o_cnt       = cnt_q;

endmodule

// File: rtl/clock_div_bank.sv
// Bank of independent clock-enable generators sharing reset and phase-align sync.
module clock_div_bank
    import clock_div_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_sync,
    input  logic [CHANNELS-1:0]       i_en,
    input  logic [CHANNELS-1:0]       i_mode,
    input  logic [CHANNELS*WIDTH-1:0] i_div,
    output logic [CHANNELS-1:0]       o_roll_over,
    output logic [CHANNELS-1:0]       o_clk,
    output logic [CHANNELS*WIDTH-1:0] o_cnt
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        clock_div_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .i_sync     (i_sync),
            .i_en       (i_en[g]),
            .i_mode     (div_mode_t'(i_mode[g])),
            .i_div      (i_div[g*WIDTH +: WIDTH]),
            .o_roll_over(o_roll_over[g]),
            .o_clk      (o_clk[g]),
            .o_cnt      (o_cnt[g*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_clock_div_bank.sv
// Directed bench for clock_div_bank: rollover timing, modes, enable hold, sync and reset.
module tb_clock_div_bank;

    localparam int CHANNELS = 4;
    localparam int WIDTH    = 8;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      i_sync;
    logic [CHANNELS-1:0]       i_en;
    logic [CHANNELS-1:0]       i_mode;
    logic [CHANNELS*WIDTH-1:0] i_div;
    logic [CHANNELS-1:0]       o_roll_over;
    logic [CHANNELS-1:0]       o_clk;
    logic [CHANNELS*WIDTH-1:0] o_cnt;

    int errors = 0;
    int checks = 0;

    clock_div_bank #(
        .CHANNELS(CHANNELS),
        .WIDTH   (WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_sync     (i_sync),
        .i_en       (i_en),
        .i_mode     (i_mode),
        .i_div      (i_div),
        .o_roll_over(o_roll_over),
        .o_clk      (o_clk),
        .o_cnt      (o_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int ch);
        return 32'(o_cnt[ch*WIDTH +: WIDTH]);
    endfunction

    task automatic set_div(input int ch, input logic [WIDTH-1:0] v);
        i_div[ch*WIDTH +: WIDTH] = v;
    endtask

    task automatic sync_pulse();
        i_sync = 1'b1;
        tick(1);
        i_sync = 1'b0;
    endtask

    initial begin
        logic [31:0] roll3_exp [10];
        logic [31:0] cnt3_exp  [10];
        roll3_exp = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1};
        cnt3_exp  = '{1, 2, 3, 4, 5, 0, 1, 0, 1, 0};

        reset  = 1'b1;
        i_sync = 1'b0;
        i_en   = '0;
        i_mode = '0;
        i_div  = '0;

        // Reset state
        set_div(0, 8'd3);
        tick(2);
        check("reset_roll", 32'(o_roll_over), 32'h0);
        check("reset_clk",  32'(o_clk),       32'h0);
        check("reset_cnt",  o_cnt,            32'h0);

        // Test 1: D=3 toggle on ch0
        reset   = 1'b0;
        i_en[0] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick(1);
            check($sformatf("t1_cnt_e%0d", e),  cnt_of(0),             32'(e % 4));
            check($sformatf("t1_roll_e%0d", e), 32'(o_roll_over[0]),   32'((e % 4) == 0));
            check($sformatf("t1_clk_e%0d", e),  32'(o_clk[0]),         32'((e / 4) % 2));
        end

        // Test 2: D=0 pulse on ch1; ch0 disabled with clk held high
        i_en      = 4'b0010;
        i_mode[1] = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick(1);
            check($sformatf("t2_roll_e%0d", e), 32'(o_roll_over[1]), 32'h1);
            check($sformatf("t2_clk_e%0d", e),  32'(o_clk[1]),       32'h1);
            check($sformatf("t2_cnt_e%0d", e),  cnt_of(1),           32'h0);
        end
        check("t2_ch0_clk_hold", 32'(o_clk[0]),       32'h1);
        check("t2_ch0_roll_off", 32'(o_roll_over[0]), 32'h0);
        i_en[1] = 1'b0;
        tick(1);
        check("t2_dis_roll", 32'(o_roll_over[1]), 32'h0);
        check("t2_dis_clk",  32'(o_clk[1]),       32'h0);
        check("t2_dis_cnt",  cnt_of(1),           32'h0);

        // Test 3: D=5, then divisor changed to 1 at cnt=2
        set_div(2, 8'd5);
        sync_pulse();
        check("t3_sync_cnt", o_cnt, 32'h0);
        i_en = 4'b0100;
        for (int e = 1; e <= 10; e++) begin
            tick(1);
            if (e == 2) set_div(2, 8'd1);
            check($sformatf("t3_cnt_e%0d", e),  cnt_of(2),           cnt3_exp[e-1]);
            check($sformatf("t3_roll_e%0d", e), 32'(o_roll_over[2]), roll3_exp[e-1]);
        end
        check("t3_clk", 32'(o_clk[2]), 32'h1);

        // Test 4: enable hold mid-count on ch3 (D=4, cnt=2, clk=1)
        i_en = '0;
        set_div(3, 8'd4);
        sync_pulse();
        i_en = 4'b1000;
        tick(7);
        check("t4_pre_cnt", cnt_of(3),     32'h2);
        check("t4_pre_clk", 32'(o_clk[3]), 32'h1);
        i_en = '0;
        for (int e = 1; e <= 3; e++) begin
            tick(1);
            check($sformatf("t4_hold_cnt_e%0d", e),  cnt_of(3),           32'h2);
            check($sformatf("t4_hold_clk_e%0d", e),  32'(o_clk[3]),       32'h1);
            check($sformatf("t4_hold_roll_e%0d", e), 32'(o_roll_over[3]), 32'h0);
        end
        i_en = 4'b1000;
        tick(2);
        check("t4_resume_cnt",  cnt_of(3),           32'h4);
        check("t4_resume_roll", 32'(o_roll_over[3]), 32'h0);
        tick(1);
        check("t4_strobe_roll", 32'(o_roll_over[3]), 32'h1);
        check("t4_strobe_clk",  32'(o_clk[3]),       32'h0);
        check("t4_strobe_cnt",  cnt_of(3),           32'h0);

        // Test 5: D=2 and D=6 out of phase, sync collides with ch0 rollover
        i_en   = '0;
        i_mode = '0;
        set_div(0, 8'd2);
        set_div(1, 8'd6);
        sync_pulse();
        i_en = 4'b0001;
        tick(1);
        i_en = 4'b0011;
        tick(1);
        check("t5_ch0_pre", cnt_of(0), 32'h2);
        check("t5_ch1_pre", cnt_of(1), 32'h1);
        sync_pulse();
        check("t5_sync_roll", 32'(o_roll_over), 32'h0);
        check("t5_sync_clk",  32'(o_clk),       32'h0);
        check("t5_sync_cnt",  o_cnt,            32'h0);
        for (int e = 1; e <= 21; e++) begin
            tick(1);
            check($sformatf("t5_roll0_e%0d", e), 32'(o_roll_over[0]), 32'((e % 3) == 0));
            check($sformatf("t5_roll1_e%0d", e), 32'(o_roll_over[1]), 32'((e % 7) == 0));
        end

        // Test 6: D=255, reset at cnt=254, then full-range period
        i_en = '0;
        set_div(0, 8'd255);
        sync_pulse();
        i_en = 4'b0001;
        tick(254);
        check("t6_pre_cnt",  cnt_of(0),           32'd254);
        check("t6_pre_roll", 32'(o_roll_over[0]), 32'h0);
        reset = 1'b1;
        tick(1);
        check("t6_rst_roll", 32'(o_roll_over), 32'h0);
        check("t6_rst_clk",  32'(o_clk),       32'h0);
        check("t6_rst_cnt",  o_cnt,            32'h0);
        reset = 1'b0;
        tick(255);
        check("t6_e255_cnt",  cnt_of(0),           32'd255);
        check("t6_e255_roll", 32'(o_roll_over[0]), 32'h0);
        tick(1);
        check("t6_e256_roll", 32'(o_roll_over[0]), 32'h1);
        check("t6_e256_cnt",  cnt_of(0),           32'h0);
        check("t6_e256_clk",  32'(o_clk[0]),       32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
